// File: rtl/circuito_p_pkg.sv
// circuito_p_pkg: shared types for the circuito_p sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: state_t (3-bit FSM encoding; code 7 is unused and recovers to IDLE)
//           and small state-class helpers.
package circuito_p_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LZ   = 3'd1,
      WR   = 3'd2,
      SS   = 3'd3,
      SD   = 3'd4,
      STZ  = 3'd5,
      WE   = 3'd6
   } state_t;

   // States in which test_out is loaded from test_in instead of counting.
   function automatic logic is_load_state(input state_t st);
      return (st == LZ) || (st == WR);
   endfunction

   // States in which the address counter is preloaded and lclk parked low.
   function automatic logic is_preload_state(input state_t st);
      return (st == IDLE) || (st == WE) || (st == LZ) || (st == WR);
   endfunction

endpackage

// File: rtl/conflict_det.sv
// conflict_det: flags CONF_DEPTH consecutive cycles of test_out == test_in.
// Latency: conflict rises CONF_DEPTH clocks after the first of the matching cycles.
// Backpressure: none; samples every cycle.
// Ports: clock, reset (async active-low), test_out/test_in (compared), conflict (AND of match history).
module conflict_det #(
   parameter int TEST_W     = 2,
   parameter int CONF_DEPTH = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [TEST_W-1:0] test_out,
   input  logic [TEST_W-1:0] test_in,
   output logic              conflict
);

   logic                  match;
   logic [CONF_DEPTH-1:0] hist;

   assign match = (test_out == test_in);

   // Depth 1 gets its own branch so the shift slice is never zero-width.
   if (CONF_DEPTH == 1) begin : g_one
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) hist <= '0;
         else        hist <= match;
      end
   end else begin : g_many
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) hist <= '0;
         else        hist <= {hist[CONF_DEPTH-2:0], match};
      end
   end

   // Built only from registered bits, so conflict is glitch-free.
   assign conflict = &hist;

endmodule

// File: rtl/circuito_p.sv
// circuito_p: start/load sequencer driving a down-counting read address, toggle clock and test counter.
// Latency: all outputs registered except fz_L (decode of current state); reset release acts on the next edge.
// Backpressure: hold freezes read_a/lclk in SS/SD/STZ; a detected conflict or s=0 aborts to IDLE.
// Ports: clock, reset (async active-low), s, dv, l_in, hold, test_in -> fz_L, lclk, read_a, test_out,
//        conflict; conflict_cnt (8-bit saturating count of conflict rises) only with CIRCUITO_P_CONFLICT_CNT_EN.
module circuito_p
   import circuito_p_pkg::*;
#(
   parameter int CNT_W      = 5,
   parameter int LOAD_VAL   = 24,
   parameter int WRAP_VAL   = 25,
   parameter int TEST_W     = 2,
   parameter int TEST_OFS   = 2,
   parameter int CONF_DEPTH = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              s,
   input  logic              dv,
   input  logic              l_in,
   input  logic              hold,
   input  logic [TEST_W-1:0] test_in,
   output logic              fz_L,
   output logic              lclk,
   output logic [CNT_W-1:0]  read_a,
   output logic [TEST_W-1:0] test_out,
   output logic              conflict
`ifdef CIRCUITO_P_CONFLICT_CNT_EN
   ,
   output logic [7:0]        conflict_cnt
`endif
);

   localparam logic [CNT_W-1:0]  LOAD_C = CNT_W'(LOAD_VAL);
   localparam logic [CNT_W-1:0]  WRAP_C = CNT_W'(WRAP_VAL);
   localparam logic [TEST_W-1:0] OFS_C  = TEST_W'(TEST_OFS);

   state_t state, state_nx;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = IDLE;
      case (state)
         IDLE:   state_nx = (s && !dv) ? WE : IDLE;
         WE:     state_nx = !s ? IDLE : (dv ? LZ : WE);
         LZ, WR: state_nx = !s ? IDLE : (l_in ? WR : SS);
         // Abort (s low or conflict) outranks the counting sequence.
         SS:     state_nx = (!s || conflict) ? IDLE : SD;
         SD:     state_nx = (!s || conflict) ? IDLE : ((read_a == '0) ? STZ : SD);
         STZ:    state_nx = (!s || conflict) ? IDLE : ((read_a == WRAP_C) ? SS : STZ);
         default: state_nx = IDLE;
      endcase
   end

   assign fz_L = (state == SD);

   // Address counter and toggle clock. The unused encoding keeps counting
   // regardless of hold for the single cycle before it recovers to IDLE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         read_a <= '0;
         lclk   <= 1'b0;
      end else if (is_preload_state(state)) begin
         read_a <= LOAD_C;
         lclk   <= 1'b0;
      end else if (!hold || !(state inside {SS, SD, STZ})) begin
         read_a <= read_a - 1'b1;
         if (read_a == WRAP_C) lclk <= ~lclk;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                    test_out <= '0;
      else if (is_load_state(state)) test_out <= test_in + OFS_C;
      else                           test_out <= test_out + 1'b1;
   end

   conflict_det #(
      .TEST_W     (TEST_W),
      .CONF_DEPTH (CONF_DEPTH)
   ) u_conflict_det (
      .clock    (clock),
      .reset    (reset),
      .test_out (test_out),
      .test_in  (test_in),
      .conflict (conflict)
   );

`ifdef CIRCUITO_P_CONFLICT_CNT_EN
   logic conflict_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         conflict_q   <= 1'b0;
         conflict_cnt <= '0;
      end else begin
         conflict_q <= conflict;
         if (conflict && !conflict_q && (conflict_cnt != 8'hFF))
            conflict_cnt <= conflict_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_circuito_p.sv
module tb_circuito_p;
   import circuito_p_pkg::*;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   // Instance A: default parameters
   logic       reset, s, dv, l_in, hold;
   logic [1:0] test_in, test_out;
   logic       fz_L, lclk, conflict;
   logic [4:0] read_a;
   // Instance B: 6-bit counter, LOAD_VAL=40, WRAP_VAL=41
   logic       s_b, dv_b, l_in_b, hold_b;
   logic [1:0] test_in_b, test_out_b;
   logic       fz_b, lclk_b, conflict_b;
   logic [5:0] read_a_b;
`ifdef CIRCUITO_P_CONFLICT_CNT_EN
   logic [7:0] conflict_cnt, conflict_cnt_b;
`endif

   circuito_p dut (
      .clock(clock), .reset(reset), .s(s), .dv(dv), .l_in(l_in), .hold(hold),
      .test_in(test_in), .fz_L(fz_L), .lclk(lclk), .read_a(read_a),
      .test_out(test_out), .conflict(conflict)
`ifdef CIRCUITO_P_CONFLICT_CNT_EN
      , .conflict_cnt(conflict_cnt)
`endif
   );

   circuito_p #(.CNT_W(6), .LOAD_VAL(40), .WRAP_VAL(41)) dut_b (
      .clock(clock), .reset(reset), .s(s_b), .dv(dv_b), .l_in(l_in_b), .hold(hold_b),
      .test_in(test_in_b), .fz_L(fz_b), .lclk(lclk_b), .read_a(read_a_b),
      .test_out(test_out_b), .conflict(conflict_b)
`ifdef CIRCUITO_P_CONFLICT_CNT_EN
      , .conflict_cnt(conflict_cnt_b)
`endif
   );

   typedef struct packed {
      logic       fz;
      logic [7:0] ra;
      logic       lk;
      logic [1:0] to;
      logic       cf;
   } exp_t;

   exp_t  exp_q[$];
   exp_t  exp_b_q[$];
   string tag_q[$];
   string tag_b_q[$];
   int    checks = 0;
   int    errors = 0;
   logic [1:0] tout;   // expected test_out of instance A

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // One clock on instance A. nst/ra/lk/cf are the expected values after the edge;
   // ld marks that the current state is LZ/WR; mt drives test_in equal to test_out.
   task automatic tick(input string tag, input state_t nst, input int ra, input logic lk,
                       input logic ld = 1'b0, input logic mt = 1'b0, input logic cf = 1'b0);
      exp_t  e;
      string t;
      test_in = mt ? tout : (tout ^ 2'd2);
      tout    = ld ? 2'(test_in + 2'd2) : 2'(tout + 2'd1);
      e.fz = (nst == SD);
      e.ra = 8'(ra);
      e.lk = lk;
      e.to = tout;
      e.cf = cf;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk({t, ".read_a"},   8'(read_a),   e.ra);
      chk({t, ".fz_L"},     8'(fz_L),     8'(e.fz));
      chk({t, ".lclk"},     8'(lclk),     8'(e.lk));
      chk({t, ".test_out"}, 8'(test_out), 8'(e.to));
      chk({t, ".conflict"}, 8'(conflict), 8'(e.cf));
   endtask

   // One clock on instance B with test_in kept away from test_out.
   task automatic tick_b(input string tag, input state_t nst, input int ra, input logic lk);
      exp_t  e;
      string t;
      test_in_b = test_out_b ^ 2'd2;
      e = '0;
      e.fz = (nst == SD);
      e.ra = 8'(ra);
      e.lk = lk;
      exp_b_q.push_back(e);
      tag_b_q.push_back(tag);
      @(posedge clock);
      #1;
      e = exp_b_q.pop_front();
      t = tag_b_q.pop_front();
      chk({t, ".read_a"},   8'(read_a_b),   e.ra);
      chk({t, ".fz_L"},     8'(fz_b),       8'(e.fz));
      chk({t, ".lclk"},     8'(lclk_b),     8'(e.lk));
      chk({t, ".conflict"}, 8'(conflict_b), 8'(e.cf));
   endtask

   initial begin
      reset = 1'b0; s = 1'b0; dv = 1'b0; l_in = 1'b0; hold = 1'b0; test_in = 2'd0;
      s_b = 1'b0; dv_b = 1'b0; l_in_b = 1'b0; hold_b = 1'b0; test_in_b = 2'd0;
      tout = 2'd0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst.read_a",   8'(read_a),   8'd0);
      chk("rst.lclk",     8'(lclk),     8'd0);
      chk("rst.test_out", 8'(test_out), 8'd0);
      chk("rst.fz_L",     8'(fz_L),     8'd0);
      chk("rst.conflict", 8'(conflict), 8'd0);
      chk("rst_b.read_a", 8'(read_a_b), 8'd0);
      reset = 1'b1;

      // Main walk: IDLE, WE, LZ, SS, SD down to 0, STZ 31..25, wrap back to SS
      tick("idle", IDLE, 24, 1'b0);
      s = 1'b1;
      tick("we", WE, 24, 1'b0);
      dv = 1'b1;
      tick("lz", LZ, 24, 1'b0);
      l_in = 1'b0;
      tick("ss", SS, 24, 1'b0, 1'b1);
      tick("sd", SD, 23, 1'b0);
      for (int r = 22; r >= 0; r--) tick("sd_cnt", SD, r, 1'b0);
      tick("stz", STZ, 31, 1'b0);
      for (int r = 30; r >= 25; r--) tick("stz_cnt", STZ, r, 1'b0);
      tick("wrap", SS, 24, 1'b1);
      tick("sd2", SD, 23, 1'b1);
      for (int r = 22; r >= 10; r--) tick("sd2_cnt", SD, r, 1'b1);

      // Freeze the counter in SD; test_out keeps counting
      hold = 1'b1;
      repeat (5) tick("hold", SD, 10, 1'b1);
      hold = 1'b0;
      tick("release", SD, 9, 1'b1);

      // Two consecutive matches raise conflict, which aborts to IDLE
      tick("match1", SD, 8, 1'b1, 1'b0, 1'b1, 1'b0);
      tick("match2", SD, 7, 1'b1, 1'b0, 1'b1, 1'b1);
      tick("conf_exit", IDLE, 6, 1'b1);
      s = 1'b0; dv = 1'b0;
      tick("reload", IDLE, 24, 1'b0);

      // Second pass through WE hold and WR, then reset mid-SD at read_a=13
      s = 1'b1;
      tick("we2", WE, 24, 1'b0);
      tick("we_stay", WE, 24, 1'b0);
      dv = 1'b1;
      tick("lz2", LZ, 24, 1'b0);
      l_in = 1'b1;
      tick("wr", WR, 24, 1'b0, 1'b1);
      tick("wr_stay", WR, 24, 1'b0, 1'b1);
      l_in = 1'b0;
      tick("ss2", SS, 24, 1'b0, 1'b1);
      tick("sd3", SD, 23, 1'b0);
      for (int r = 22; r >= 13; r--) tick("sd3_cnt", SD, r, 1'b0);
      reset = 1'b0;
      #1;
      chk("midrst.read_a",   8'(read_a),   8'd0);
      chk("midrst.lclk",     8'(lclk),     8'd0);
      chk("midrst.test_out", 8'(test_out), 8'd0);
      chk("midrst.fz_L",     8'(fz_L),     8'd0);
      s = 1'b0; dv = 1'b0;
      tout = 2'd0;
      reset = 1'b1;
      tick("post_rst", IDLE, 24, 1'b0);

      // Instance B: wider counter, SD 39..0, STZ 63..41, toggle at 41, abort from SS
      s_b = 1'b1;
      tick_b("b_we", WE, 40, 1'b0);
      dv_b = 1'b1;
      tick_b("b_lz", LZ, 40, 1'b0);
      tick_b("b_ss", SS, 40, 1'b0);
      tick_b("b_sd", SD, 39, 1'b0);
      for (int r = 38; r >= 0; r--) tick_b("b_sd_cnt", SD, r, 1'b0);
      tick_b("b_stz", STZ, 63, 1'b0);
      for (int r = 62; r >= 41; r--) tick_b("b_stz_cnt", STZ, r, 1'b0);
      tick_b("b_wrap", SS, 40, 1'b1);
      s_b = 1'b0; dv_b = 1'b0;
      tick_b("b_abort", IDLE, 39, 1'b1);
      tick_b("b_reload", IDLE, 40, 1'b0);

`ifdef CIRCUITO_P_CONFLICT_CNT_EN
      // 300 conflict pulses on instance B: two matches then two misses each
      for (int p = 0; p < 300; p++) begin
         test_in_b = test_out_b;
         @(posedge clock); #1;
         test_in_b = test_out_b;
         @(posedge clock); #1;
         if (p == 0) chk("cnt.conflict_pulse", 8'(conflict_b), 8'd1);
         test_in_b = test_out_b ^ 2'd2;
         @(posedge clock); #1;
         test_in_b = test_out_b ^ 2'd2;
         @(posedge clock); #1;
         if (p == 2) chk("cnt.after3", conflict_cnt_b, 8'd3);
      end
      chk("cnt.saturate", conflict_cnt_b, 8'd255);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
